code_entry: RTL and testbench

CODE_ENTRY -- requirements
Module: code_entry

---
 rtl/code_entry.sv | 237 +++++++++++++++++++++++
 tb/tb_code_entry.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/code_entry.sv
// Keypad code-entry controller: collects a four-digit BCD code after an 'A'
// start key, checks it on '#', and locks out after repeated failures.
module code_entry #(
  parameter logic [15:0] CODE        = 16'h4693,
  parameter int unsigned TIMEOUT_CYC = 150_000_000,
  parameter int unsigned LOCK_CYC    = 1_500_000_000,
  parameter int unsigned MAX_FAIL    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       arm,
  output logic       start_req,
  output logic       code_ok,
  output logic       code_bad,
  output logic       timeout,
  output logic       locked,
  output logic [2:0] digit_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_ENTRY,
    S_CHECK,
    S_LOCKOUT
  } state_e;

  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0] LOCK_LAST = 32'(LOCK_CYC - 1);
  localparam logic [1:0]  FAIL_MAX  = 2'(MAX_FAIL);

  localparam logic [3:0] KEY_START = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hE;
  localparam logic [3:0] KEY_ENTER = 4'hF;

  state_e      state_q, state_d;
  logic [15:0] buf_q, buf_d;
  logic [2:0]  digit_cnt_q, digit_cnt_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic [31:0] lock_cnt_q, lock_cnt_d;
  logic [1:0]  fail_q, fail_d;
  logic        start_req_q, start_req_d;
  logic        code_ok_q, code_ok_d;
  logic        code_bad_q, code_bad_d;
  logic        timeout_q, timeout_d;
  logic        locked_q, locked_d;

  // Key decode and shared conditions used by both the next-state and output logic.
  logic       key_digit, key_start, key_clear, key_enter;
  logic       entry_live, buf_full, code_match;
  logic       short_enter, check_fail, fail_event, fail_lock;
  logic       tmo_expire, lock_done;
  logic [1:0] fail_inc;

  assign key_digit = key_valid && (key_code <= 4'd9);
  assign key_start = key_valid && (key_code == KEY_START);
  assign key_clear = key_valid && (key_code == KEY_CLEAR);
  assign key_enter = key_valid && (key_code == KEY_ENTER);

  assign entry_live  = (state_q == S_ENTRY) && arm;
  assign buf_full    = (digit_cnt_q == 3'd4);
  assign code_match  = (buf_q == CODE);
  assign short_enter = entry_live && key_enter && !buf_full;
  assign check_fail  = (state_q == S_CHECK) && !code_match;
  assign fail_event  = short_enter || check_fail;
  assign fail_inc    = (fail_q >= FAIL_MAX) ? fail_q : fail_q + 2'd1;
  assign fail_lock   = fail_event && (fail_inc == FAIL_MAX);
  assign tmo_expire  = entry_live && !key_valid && (tmo_cnt_q == TMO_LAST);
  assign lock_done   = (state_q == S_LOCKOUT) && (lock_cnt_q == LOCK_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A lockout decision outranks arm going low.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (arm) state_d = S_READY;
      end
      S_READY: begin
        if (!arm)           state_d = S_IDLE;
        else if (key_start) state_d = S_ENTRY;
      end
      S_ENTRY: begin
        if (!arm)                       state_d = S_IDLE;
        else if (fail_lock)             state_d = S_LOCKOUT;
        else if (key_enter && buf_full) state_d = S_CHECK;
        else if (tmo_expire)            state_d = S_READY;
      end
      S_CHECK: begin
        if (fail_lock)       state_d = S_LOCKOUT;
        else if (!arm)       state_d = S_IDLE;
        else if (code_match) state_d = S_READY;
        else                 state_d = S_ENTRY;
      end
      S_LOCKOUT: begin
        if (lock_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    buf_d       = buf_q;
    digit_cnt_d = digit_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    lock_cnt_d  = '0;
    fail_d      = fail_q;
    start_req_d = 1'b0;
    code_ok_d   = 1'b0;
    code_bad_d  = 1'b0;
    timeout_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        buf_d       = '0;
        digit_cnt_d = '0;
        tmo_cnt_d   = '0;
      end
      S_READY: begin
        if (arm && key_start) begin
          start_req_d = 1'b1;
          buf_d       = '0;
          digit_cnt_d = '0;
          tmo_cnt_d   = '0;
        end
      end
      S_ENTRY: begin
        if (!arm) begin
          buf_d       = '0;
          digit_cnt_d = '0;
          tmo_cnt_d   = '0;
        end else if (key_valid) begin
          // Any key, even an ignored one, restarts the idle timer.
          tmo_cnt_d = '0;
          if (key_digit && !buf_full) begin
            buf_d       = {buf_q[11:0], key_code};
            digit_cnt_d = digit_cnt_q + 3'd1;
          end else if (key_clear) begin
            buf_d       = '0;
            digit_cnt_d = '0;
          end else if (key_start) begin
            start_req_d = 1'b1;
            buf_d       = '0;
            digit_cnt_d = '0;
          end else if (short_enter) begin
            code_bad_d  = 1'b1;
            fail_d      = fail_inc;
            buf_d       = '0;
            digit_cnt_d = '0;
          end
        end else if (tmo_expire) begin
          timeout_d   = 1'b1;
          buf_d       = '0;
          digit_cnt_d = '0;
          tmo_cnt_d   = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
      end
      S_CHECK: begin
        buf_d       = '0;
        digit_cnt_d = '0;
        tmo_cnt_d   = '0;
        if (code_match) begin
          code_ok_d = 1'b1;
          fail_d    = '0;
        end else begin
          code_bad_d = 1'b1;
          fail_d     = fail_inc;
        end
      end
      S_LOCKOUT: begin
        if (lock_done) begin
          fail_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 32'd1;
        end
      end
      default: begin
        buf_d       = '0;
        digit_cnt_d = '0;
        tmo_cnt_d   = '0;
      end
    endcase

    locked_d = (state_d == S_LOCKOUT);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q       <= '0;
      digit_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      lock_cnt_q  <= '0;
      fail_q      <= '0;
      start_req_q <= 1'b0;
      code_ok_q   <= 1'b0;
      code_bad_q  <= 1'b0;
      timeout_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      digit_cnt_q <= digit_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      fail_q      <= fail_d;
      start_req_q <= start_req_d;
      code_ok_q   <= code_ok_d;
      code_bad_q  <= code_bad_d;
      timeout_q   <= timeout_d;
      locked_q    <= locked_d;
    end
  end

  assign start_req   = start_req_q;
  assign code_ok     = code_ok_q;
  assign code_bad    = code_bad_q;
  assign timeout     = timeout_q;
  assign locked      = locked_q;
  assign digit_count = digit_cnt_q;

endmodule

// File: tb/tb_code_entry.sv
// Directed bench for code_entry: a vector table for the main entry flows plus
// hand-written sequences for timeout, arm drop and reset corners.
module tb_code_entry;

  localparam int unsigned TMO  = 20;
  localparam int unsigned LOCK = 12;

  localparam logic [4:0] P0   = 5'b00000;
  localparam logic [4:0] PST  = 5'b10000;
  localparam logic [4:0] POK  = 5'b01000;
  localparam logic [4:0] PBAD = 5'b00100;
  localparam logic [4:0] PTO  = 5'b00010;
  localparam logic [4:0] PLK  = 5'b00001;

  localparam logic [3:0] KA = 4'hA;
  localparam logic [3:0] KB = 4'hB;
  localparam logic [3:0] KE = 4'hE;
  localparam logic [3:0] KF = 4'hF;

  typedef struct {
    string      name;
    logic       kv;
    logic [3:0] key;
    logic       arm;
    logic [4:0] exp_p;    // {start_req, code_ok, code_bad, timeout, locked}
    logic [2:0] exp_cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       arm;
  logic       start_req, code_ok, code_bad, timeout, locked;
  logic [2:0] digit_count;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t tbl[$];

  code_entry #(
    .CODE       (16'h4693),
    .TIMEOUT_CYC(TMO),
    .LOCK_CYC   (LOCK),
    .MAX_FAIL   (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .arm        (arm),
    .start_req  (start_req),
    .code_ok    (code_ok),
    .code_bad   (code_bad),
    .timeout    (timeout),
    .locked     (locked),
    .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(string n, logic kv, logic [3:0] k, logic a,
                              logic [4:0] p, logic [2:0] c);
    vec_t v;
    v.name = n; v.kv = kv; v.key = k; v.arm = a; v.exp_p = p; v.exp_cnt = c;
    return v;
  endfunction

  function automatic vec_t key_v(string n, logic [3:0] k, logic [4:0] p, logic [2:0] c);
    return mk(n, 1'b1, k, 1'b1, p, c);
  endfunction

  function automatic vec_t idle_v(string n, logic a, logic [4:0] p, logic [2:0] c);
    return mk(n, 1'b0, 4'h0, a, p, c);
  endfunction

  // One vector = one clock edge; outputs are sampled 1 time unit after it.
  task automatic apply(input vec_t v);
    @(negedge clk);
    key_valid = v.kv;
    key_code  = v.key;
    arm       = v.arm;
    @(posedge clk);
    #1;
    check({v.name, ".start_req"},   32'(start_req),   32'(v.exp_p[4]));
    check({v.name, ".code_ok"},     32'(code_ok),     32'(v.exp_p[3]));
    check({v.name, ".code_bad"},    32'(code_bad),    32'(v.exp_p[2]));
    check({v.name, ".timeout"},     32'(timeout),     32'(v.exp_p[1]));
    check({v.name, ".locked"},      32'(locked),      32'(v.exp_p[0]));
    check({v.name, ".digit_count"}, 32'(digit_count), 32'(v.exp_cnt));
  endtask

  task automatic apply_reset(input string name, input logic kv, input logic [3:0] k);
    @(negedge clk);
    reset     = 1'b1;
    key_valid = kv;
    key_code  = k;
    arm       = 1'b1;
    @(posedge clk);
    #1;
    check({name, ".outputs"}, 32'({start_req, code_ok, code_bad, timeout, locked}), 32'(0));
    check({name, ".digit_count"}, 32'(digit_count), 32'(0));
  endtask

  task automatic enter_code(input logic [3:0] d0, input logic [3:0] d1,
                            input logic [3:0] d2, input logic [3:0] d3);
    apply(key_v("digit1", d0, P0, 3'd1));
    apply(key_v("digit2", d1, P0, 3'd2));
    apply(key_v("digit3", d2, P0, 3'd3));
    apply(key_v("digit4", d3, P0, 3'd4));
  endtask

  initial begin
    logic [3:0] lock_keys [4];
    lock_keys = '{KA, 4'h4, KF, KE};

    reset = 1'b1; key_valid = 1'b0; key_code = 4'h0; arm = 1'b0;
    apply_reset("reset_a", 1'b0, 4'h0);
    apply_reset("reset_b", 1'b0, 4'h0);
    @(negedge clk);
    reset = 1'b0;

    // Correct code, fifth-digit ignore, three wrong codes into lockout, short entry.
    tbl.push_back(idle_v("arm_to_ready", 1'b1, P0, 3'd0));
    tbl.push_back(key_v("ready_ignores_digit", 4'h4, P0, 3'd0));
    tbl.push_back(key_v("start_a", KA, PST, 3'd0));
    tbl.push_back(key_v("ok_d4", 4'h4, P0, 3'd1));
    tbl.push_back(key_v("ok_d6", 4'h6, P0, 3'd2));
    tbl.push_back(key_v("ok_d9", 4'h9, P0, 3'd3));
    tbl.push_back(key_v("ok_d3", 4'h3, P0, 3'd4));
    tbl.push_back(key_v("ok_enter", KF, P0, 3'd4));
    tbl.push_back(idle_v("ok_pulse", 1'b1, POK, 3'd0));
    tbl.push_back(idle_v("ok_one_cycle", 1'b1, P0, 3'd0));
    tbl.push_back(key_v("five_start", KA, PST, 3'd0));
    tbl.push_back(key_v("five_d4", 4'h4, P0, 3'd1));
    tbl.push_back(key_v("five_d6", 4'h6, P0, 3'd2));
    tbl.push_back(key_v("five_d9", 4'h9, P0, 3'd3));
    tbl.push_back(key_v("five_d3", 4'h3, P0, 3'd4));
    tbl.push_back(key_v("fifth_ignored", 4'h7, P0, 3'd4));
    tbl.push_back(key_v("five_enter", KF, P0, 3'd4));
    tbl.push_back(idle_v("five_ok", 1'b1, POK, 3'd0));
    for (int r = 0; r < 3; r++) begin
      tbl.push_back(key_v("bad_start", KA, PST, 3'd0));
      tbl.push_back(key_v("bad_d4", 4'h4, P0, 3'd1));
      tbl.push_back(key_v("bad_d6", 4'h6, P0, 3'd2));
      tbl.push_back(key_v("bad_d9", 4'h9, P0, 3'd3));
      tbl.push_back(key_v("bad_d2", 4'h2, P0, 3'd4));
      tbl.push_back(key_v("bad_enter", KF, P0, 3'd4));
      tbl.push_back(idle_v("bad_pulse", 1'b1, (r == 2) ? (PBAD | PLK) : PBAD, 3'd0));
    end
    for (int i = 0; i < int'(LOCK) - 1; i++)
      tbl.push_back(mk("lock_hold", 1'b1, lock_keys[i % 4], 1'(i % 2), PLK, 3'd0));
    tbl.push_back(idle_v("lock_release", 1'b1, P0, 3'd0));
    tbl.push_back(mk("idle_arm_low", 1'b1, KA, 1'b0, P0, 3'd0));
    tbl.push_back(idle_v("rearm", 1'b1, P0, 3'd0));
    tbl.push_back(key_v("clr_start", KA, PST, 3'd0));
    tbl.push_back(key_v("clr_d4", 4'h4, P0, 3'd1));
    tbl.push_back(key_v("clr_d6", 4'h6, P0, 3'd2));
    tbl.push_back(key_v("clr_star", KE, P0, 3'd0));
    tbl.push_back(key_v("clr_d9", 4'h9, P0, 3'd1));
    tbl.push_back(key_v("clr_d3", 4'h3, P0, 3'd2));

    foreach (tbl[i]) apply(tbl[i]);

    check("buffer_after_clear", 32'(dut.buf_q), 32'h0093);
    apply(key_v("short_enter", KF, PBAD, 3'd0));
    apply(key_v("key_b_ignored", KB, P0, 3'd0));

    // Idle timeout: fires TMO clocks after the last key, not counted as a failure.
    apply(key_v("tmo_d4", 4'h4, P0, 3'd1));
    for (int i = 0; i < int'(TMO) - 1; i++) apply(idle_v("tmo_wait", 1'b1, P0, 3'd1));
    apply(idle_v("timeout_pulse", 1'b1, PTO, 3'd0));
    apply(key_v("ready_after_tmo", 4'h4, P0, 3'd0));
    apply(key_v("tmo2_start", KA, PST, 3'd0));
    apply(key_v("tmo2_d4", 4'h4, P0, 3'd1));
    for (int i = 0; i < int'(TMO) - 1; i++) apply(idle_v("tmo2_wait", 1'b1, P0, 3'd1));
    apply(key_v("key_on_expiry", 4'h6, P0, 3'd2));
    for (int i = 0; i < int'(TMO) - 1; i++) apply(idle_v("tmo3_wait", 1'b1, P0, 3'd2));
    apply(key_v("tmo3_d9", 4'h9, P0, 3'd3));
    apply(key_v("tmo3_d2", 4'h2, P0, 3'd4));
    apply(key_v("tmo3_enter", KF, P0, 3'd4));
    apply(idle_v("bad_not_locked", 1'b1, PBAD, 3'd0));

    // Arm dropped mid-entry.
    apply(key_v("drop_d4", 4'h4, P0, 3'd1));
    apply(key_v("drop_d6", 4'h6, P0, 3'd2));
    apply(idle_v("arm_drop", 1'b0, P0, 3'd0));
    apply(idle_v("arm_low", 1'b0, P0, 3'd0));

    // Reset mid-entry, with a key presented on the reset edge.
    apply(idle_v("rst_rearm", 1'b1, P0, 3'd0));
    apply(key_v("rst_start", KA, PST, 3'd0));
    apply(key_v("rst_d4", 4'h4, P0, 3'd1));
    apply(key_v("rst_d6", 4'h6, P0, 3'd2));
    apply(key_v("rst_d9", 4'h9, P0, 3'd3));
    apply_reset("reset_mid_entry", 1'b1, KF);
    @(negedge clk);
    reset = 1'b0;
    apply(idle_v("rst_idle_hold", 1'b0, P0, 3'd0));

    // Reset cleared the failure count: one wrong code must not lock.
    apply(idle_v("post_rst_arm", 1'b1, P0, 3'd0));
    apply(key_v("post_rst_start", KA, PST, 3'd0));
    enter_code(4'h4, 4'h6, 4'h9, 4'h2);
    apply(key_v("post_rst_enter", KF, P0, 3'd4));
    apply(idle_v("post_rst_bad", 1'b1, PBAD, 3'd0));

    // Arm dropped during CHECK: result pulse still issued, then IDLE.
    enter_code(4'h4, 4'h6, 4'h9, 4'h3);
    apply(key_v("chk_enter", KF, P0, 3'd4));
    apply(idle_v("check_arm_drop", 1'b0, POK, 3'd0));
    apply(mk("idle_after_check", 1'b1, KA, 1'b0, P0, 3'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
